// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int BYTE_W    = 8;
    localparam int MAX_WORDS = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    // A word count is usable when it is non-zero and fits the memory.
    function automatic logic count_ok(input logic [BYTE_W-1:0] n, input int num_words);
        return (n != '0) && (32'(n) <= num_words);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler: the first byte of a word lands in
// bits 7:0. word_valid_o fires combinationally with the last byte of a word
// so the caller can register the write in the same edge the byte is taken.
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 byte_valid_i,
    input  logic [BYTE_W-1:0]    byte_i,
    output logic                 word_valid_o,
    output logic [DATAWIDTH-1:0] word_o
);

    localparam int BYTES = DATAWIDTH / BYTE_W;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [CW-1:0]        cnt;
    logic [DATAWIDTH-1:0] shreg;
    logic                 last;

    assign last         = (cnt == CW'(BYTES - 1));
    assign word_valid_o = byte_valid_i && last;

    generate
        if (BYTES == 1) begin : g_single
            assign word_o = byte_i;
        end else begin : g_multi
            assign word_o = {byte_i, shreg[DATAWIDTH-1:BYTE_W]};
        end
    endgenerate

    // Shift bytes in from the top; clearing drops any partial word.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (byte_valid_i) begin
            shreg <= word_o;
            cnt   <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: count byte, N little-endian words, then (with
// IMEM_LOADER_CHECKSUM_EN defined) an XOR checksum byte. Holds the core in
// reset until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int NUMWORDS  = 32,
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 in_valid_i,
    input  logic [7:0]           in_data_i,
    output logic                 in_ready_o,
    output logic                 we_o,
    output logic [31:0]          waddr_o,
    output logic [DATAWIDTH-1:0] wdata_o,
    output logic                 cpu_rst_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam int BYTES = DATAWIDTH / BYTE_W;

    state_t               state, state_nxt;
    logic [7:0]           n_words;
    logic [7:0]           widx;
    logic                 fire;
    logic                 data_fire;
    logic                 word_valid;
    logic                 last_word;
    logic [DATAWIDTH-1:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    assign in_ready_o = (state == ST_COUNT) || (state == ST_DATA) || (state == ST_CHECK);
    assign fire       = in_valid_i && in_ready_o;
    assign data_fire  = fire && (state == ST_DATA);
    assign last_word  = word_valid && ((widx + 8'd1) == n_words);

    word_assembler #(.DATAWIDTH(DATAWIDTH)) u_asm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (state != ST_DATA),
        .byte_valid_i (data_fire),
        .byte_i       (in_data_i),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_i) state_nxt = ST_COUNT;
            ST_COUNT: if (fire) state_nxt = count_ok(in_data_i, NUMWORDS) ? ST_DATA : ST_ERROR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_DATA:  if (last_word) state_nxt = ST_CHECK;
            ST_CHECK: if (fire) state_nxt = (in_data_i == csum) ? ST_DONE : ST_ERROR;
`else
            ST_DATA:  if (last_word) state_nxt = ST_DONE;
`endif
            ST_DONE,
            ST_ERROR: if (start_i) state_nxt = ST_COUNT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Write port, word index and status flags. Flags follow the settled
    // state, so done_o rises one edge after the final write is issued and
    // drops in the very next cycle when a restart leaves DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_words   <= '0;
            widx      <= '0;
            we_o      <= 1'b0;
            waddr_o   <= '0;
            wdata_o   <= '0;
            cpu_rst_o <= 1'b1;
            done_o    <= 1'b0;
            error_o   <= 1'b0;
        end else begin
            we_o <= word_valid;
            if (word_valid) begin
                waddr_o <= 32'(widx) * 32'(BYTES);
                wdata_o <= word;
                widx    <= widx + 8'd1;
            end
            if ((state == ST_COUNT) && fire) begin
                n_words <= in_data_i;
                widx    <= '0;
            end
            cpu_rst_o <= !((state == ST_DONE) && (state_nxt == ST_DONE));
            done_o    <= (state == ST_DONE) && (state_nxt == ST_DONE);
            error_o   <= (state == ST_ERROR) && (state_nxt == ST_ERROR);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of data bytes; the count byte is not included.
    always_ff @(posedge clk_i) begin
        if (rst_i || (state == ST_COUNT)) csum <= '0;
        else if (data_fire)               csum <= csum ^ in_data_i;
    end
`endif

endmodule
